// File: rtl/mul_unit_seq_if.sv
// Request/response bundle between the execute stage (master) and mul_unit_seq (slave).
interface mul_unit_seq_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport slave (
        input  flush, in_valid, op, rs1, rs2, out_ready,
        output in_ready, out_valid, result, busy
    );

    modport master (
        output flush, in_valid, op, rs1, rs2, out_ready,
        input  in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mul_unit_seq.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU, BITS_PER_CYCLE multiplier bits per cycle.
// Optional feature: define MUL_EARLY_OUT_EN to finish as soon as the remaining multiplier bits are zero.
module mul_unit_seq #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic          clk,
    input logic          rst_n,
    mul_unit_seq_if.slave bus
);
    localparam int K  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int W2 = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [W2-1:0]   acc_q, acc_d;
    logic [W2-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [1:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            sign1, sign2;
    logic [XLEN-1:0] mag1, mag2;
    logic [W2-1:0]   acc_step, prod;
    logic [XLEN-1:0] mplier_shift;
    logic            last_iter;
    logic            accept, finish;

    // Signed operands are reduced to magnitudes; the product sign is restored at the end.
    always_comb begin
        sign1 = bus.rs1[XLEN-1] && ((bus.op == 2'b01) || (bus.op == 2'b10));
        sign2 = bus.rs2[XLEN-1] && (bus.op == 2'b01);
        mag1  = sign1 ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
        mag2  = sign2 ? (~bus.rs2 + XLEN'(1)) : bus.rs2;
    end

    always_comb begin
        acc_step = acc_q;
        for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) begin
                acc_step = acc_step + (mcand_q << j);
            end
        end
        mplier_shift = mplier_q >> BITS_PER_CYCLE;
        prod         = neg_q ? (~acc_step + W2'(1)) : acc_step;
    end

`ifdef MUL_EARLY_OUT_EN
    always_comb begin
        last_iter = (cnt_q == CW'(K - 1)) || (mplier_shift == '0);
    end
`else
    always_comb begin
        last_iter = (cnt_q == CW'(K - 1));
    end
`endif

    always_comb begin
        accept = bus.in_valid && (state_q == S_IDLE) && !bus.flush;
        finish = (state_q == S_CALC) && last_iter && !bus.flush;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (bus.in_valid) state_d = S_CALC;
                S_CALC:  if (last_iter) state_d = S_DONE;
                S_DONE:  if (bus.out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        if (accept) begin
            acc_d    = '0;
            mcand_d  = {{XLEN{1'b0}}, mag1};
            mplier_d = mag2;
            op_d     = bus.op;
            neg_d    = sign1 ^ sign2;
            cnt_d    = '0;
        end else if (state_q == S_CALC) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_shift;
            cnt_d    = cnt_q + CW'(1);
        end
        if (finish) begin
            result_d = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
        end
    end

    // Outputs
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE) && !bus.flush;
        bus.out_valid = (state_q == S_DONE);
        bus.busy      = (state_q != S_IDLE);
        bus.result    = result_q;
    end
endmodule

// File: tb/tb_mul_unit_seq.sv
// Randomised bench for mul_unit_seq against a transaction-level model (64-bit arithmetic products).
module tb_mul_unit_seq;
    localparam int XLEN = 32;
    localparam int B    = 1;
    localparam int K    = XLEN / B;
`ifdef MUL_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul_unit_seq_if #(.XLEN(XLEN)) bus ();

    mul_unit_seq #(.XLEN(XLEN), .BITS_PER_CYCLE(B)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            2'b01:   p = sa * sb;
            2'b10:   p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int n;
        m = (op == 2'b01 && b[31]) ? (32'h0 - b) : b;
        n = 0;
        for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
        n = (n + B - 1) / B;
        if (n < 1) n = 1;
        return EARLY ? n : K;
    endfunction

    // Transaction-level model: 0 idle, 1 computing, 2 result pending
    int          m_phase = 0;
    int          m_left  = 0;
    logic [31:0] m_exp   = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = 0;
        end else if (bus.flush) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (bus.in_valid) begin
                m_phase = 1;
                m_left  = ref_lat(bus.op, bus.rs2);
                m_exp   = ref_mul(bus.op, bus.rs1, bus.rs2);
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
        end else if (bus.out_ready) begin
            m_phase = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_result", bus.result, 0);
            check("rst_in_ready", bus.in_ready, !bus.flush);
        end else begin
            check("cyc_out_valid", bus.out_valid, m_phase == 2);
            check("cyc_in_ready", bus.in_ready, (m_phase == 0) && !bus.flush);
            check("cyc_busy", bus.busy, m_phase != 0);
            if (m_phase == 2) check("cyc_result", bus.result, m_exp);
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] res, output int lat, output int nrdy);
        @(posedge clk); #2;
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.rs1       = a;
        bus.rs2       = b;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom);
        bus.rs1      = $urandom;
        bus.rs2      = $urandom;
        lat  = 0;
        nrdy = int'(!bus.in_ready);
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            nrdy += int'(!bus.in_ready);
        end
        check("done_reached", bus.out_valid, 1);
        res = bus.result;
        repeat (hold) begin
            @(posedge clk); #1;
            nrdy += int'(!bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("wait_done_reached", bus.out_valid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res, a, b;
        logic [1:0]  op;
        int          lat, nrdy, seen, hold;

        rst_n         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.op        = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_result", bus.result, 0);

        do_op(2'b00, 32'd6, 32'd7, 0, res, lat, nrdy);
        check("mul_6x7", res, 32'h0000_002A);
        check("mul_6x7_latency", lat, EARLY ? 3 : 32);
        check("mul_6x7_in_ready_low", nrdy, EARLY ? 4 : 33);

        do_op(2'b00, 32'd5, 32'hFFFF_FFFD, 0, res, lat, nrdy);
        check("mul_5xm3", res, 32'hFFFF_FFF1);
        do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, nrdy);
        check("mulhsu_m1", res, 32'hFFFF_FFFF);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, nrdy);
        check("mul_m1", res, 32'h0000_0001);
        do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, res, lat, nrdy);
        check("mulh_min", res, 32'h4000_0000);
        do_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat, nrdy);
        check("mulhu_max", res, 32'hFFFF_FFFE);
        do_op(2'b00, 32'd7, 32'd3, 0, res, lat, nrdy);
        check("mul_7x3", res, 32'd21);
        check("mul_7x3_latency", lat, EARLY ? 2 : 32);
        do_op(2'b00, 32'd9, 32'd0, 0, res, lat, nrdy);
        check("mul_9x0", res, 32'd0);
        check("mul_9x0_latency", lat, EARLY ? 1 : 32);

        // Back-pressure with a second request raised while the first result is pending
        @(posedge clk); #2;
        bus.in_valid = 1'b1; bus.op = 2'b00; bus.rs1 = 32'd11; bus.rs2 = 32'd13;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.rs1 = 32'd3; bus.rs2 = 32'd5;
        wait_done(lat);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_result_stable", bus.result, 32'd143);
            check("bp_in_ready_low", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_after_handshake", bus.busy, 0);
        @(posedge clk); #1;
        check("bp_second_accepted", bus.busy, 1);
        bus.in_valid = 1'b0;
        wait_done(lat);
        check("bp_second_result", bus.result, 32'd15);
        @(posedge clk); #1;

        // Flush during the fifth CALC cycle
        @(posedge clk); #2;
        bus.in_valid = 1'b1; bus.op = 2'b00; bus.rs1 = $urandom; bus.rs2 = $urandom | 32'h8000_0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_to_idle", bus.busy, 0);
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("flush_blocks_request", bus.busy, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen += int'(bus.out_valid);
        end
        check("flush_no_out_valid", seen, 0);
        do_op(2'b00, 32'd120, 32'd140, 0, res, lat, nrdy);
        check("mul_120x140", res, 32'h0000_41A0);

        // Asynchronous reset mid-CALC
        @(posedge clk); #2;
        bus.in_valid = 1'b1; bus.op = 2'b11; bus.rs1 = $urandom; bus.rs2 = 32'hF000_0000;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_in_ready", bus.in_ready, 1);
        check("arst_busy", bus.busy, 0);
        check("arst_result", bus.result, 0);
        @(posedge clk); #2 rst_n = 1'b1;

        for (int n = 0; n < 150; n++) begin
            op = 2'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: a = 32'h7FFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'h8000_0000;
                3: b = $urandom_range(0, 255);
                default: b = $urandom;
            endcase
            hold = $urandom_range(0, 3);
            do_op(op, a, b, hold, res, lat, nrdy);
            check("rand_latency", lat, ref_lat(op, b));
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mul_unit_seq.md
# mul_unit_seq

Iterative RV32M/RV64M multiply unit for the cpu_top execute stage. It replaces the single-cycle MUL datapath and implements all four M-extension multiply ops: MUL, MULH, MULHSU and MULHU. It has a parametrised operand width and a parametrised number of multiplier bits retired per cycle. The execute stage connects through a valid/ready request port and a valid/ready response port, and can flush the unit when a branch mispredicts.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- BITS_PER_CYCLE, 1: multiplier bits retired per CALC cycle; 1, 2 or 4; must divide XLEN.
- Derived K = XLEN/BITS_PER_CYCLE.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of any in-flight op.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept; = (state==IDLE) && !flush.
- op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- rs1  in  XLEN  multiplicand operand.
- rs2  in  XLEN  multiplier operand.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  selected product half.
- busy  out  1  high in CALC or DONE.

## Operation
- States are IDLE, CALC and DONE. The reset state is IDLE.
- **IDLE:** on in_valid && in_ready, capture the operands and go to CALC.
  - rs1 is signed for MULH and MULHSU. rs2 is signed for MULH only.
  - Signed operands are stored as magnitudes (two's-complement negate if the MSB is set).
  - neg_flag = sign1 XOR sign2, using only the signed operands.
  - Capture op. Clear the 2·XLEN accumulator.
  - mcand = zero-extended |rs1| (2·XLEN wide). mplier = |rs2|.
- **CALC:** each cycle, for j in 0..BITS_PER_CYCLE-1:
  - acc += mcand<<j when mplier[j] is set.
  - Then mcand <<= BITS_PER_CYCLE and mplier >>= BITS_PER_CYCLE.
  - Iteration counter runs 0..K-1. On the K-th CALC cycle, load result and go to DONE.
- **Result select:**
  - P = neg_flag ? (~acc + 1) : acc, all 2·XLEN wide.
  - MUL selects P[XLEN-1:0]. All other ops select P[2·XLEN-1:XLEN].
  - Magnitude of the most-negative value is 2^(XLEN-1); this is handled exactly by the unsigned magnitude path.
- **DONE:**
  - out_valid=1. result is held stable until out_ready.
  - On out_valid && out_ready, go to IDLE.
  - No new request is accepted in that same cycle.
- **flush** has the highest priority. In any state, the next state is IDLE and out_valid drops the next cycle. Any result is discarded. A request presented with flush is not accepted.
- Changes to rs1, rs2 or op after capture have no effect.

## Timing
- Reset values: state IDLE, in_ready=1 (when flush=0), out_valid=0, busy=0, result=0, acc=0, counter=0.
- Latency from accept edge to out_valid high is exactly K cycles with the macro off: 32 at XLEN=32, BITS_PER_CYCLE=1; 8 at BITS_PER_CYCLE=4.
- Throughput is one op per K+2 cycles minimum (accept, K CALC, one DONE cycle with out_ready=1, return to IDLE).
- out_ready held low stalls DONE indefinitely, with result unchanged.
- If rst_n is asserted mid-operation, the unit returns to reset values immediately, asynchronously. No partial result is ever presented.
- in_valid is sampled only in IDLE. in_valid in other states is ignored, not queued.

## Configuration
- **MUL_EARLY_OUT_EN defined:** in CALC, when the post-shift mplier == 0, load result and go to DONE at that edge, without waiting for the counter.
  - Also checked at capture: |rs2|==0 gives DONE after exactly 1 CALC cycle.
  - Latency = max(1, ceil(msb_index(|rs2|)+1 / BITS_PER_CYCLE)) cycles.
  - Results are bit-identical to the macro-undefined build.
- **MUL_EARLY_OUT_EN undefined:** the fixed K-cycle latency always applies. The comparator logic is not synthesised.

## Test plan
- MUL rs1=6, rs2=7, XLEN=32, B=1, out_ready=1: result 0x0000002A, out_valid exactly 32 cycles after accept, in_ready low for 33 cycles.
- MUL 5 × −3 (0xFFFFFFFD): result 0xFFFFFFF1. MULHSU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF: result 0xFFFFFFFF; companion MUL gives 0x00000001.
- MULH 0x80000000 × 0x80000000: result 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF: result 0xFFFFFFFE.
- Back-pressure: out_ready low for 10 cycles in DONE gives result stable and in_ready=0 throughout; a new request raised during DONE is accepted only after the handshake plus one cycle.
- flush asserted at CALC cycle 5, followed by MUL 120 × 140: first op never produces out_valid; second returns 0x000041A0.
- MUL_EARLY_OUT_EN on: MUL 7 × 3 returns 21 after 2 cycles (B=1); MUL 9 × 0 after 1 cycle. Async rst_n pulse mid-CALC gives out_valid=0 and in_ready=1 immediately.
